// File: rtl/wb_team_interconnect_pkg.sv
// wb_ic_pkg: shared constants, state encoding and helpers for the Wishbone
// team interconnect.
//   DAT_W       data bus width
//   SLOT_*      fixed slot numbers; team i+1 sits at slot SLOT_TEAM0+i
//   state_e     interconnect FSM encoding
//   sat_inc16   16-bit saturating increment used by the error counter
package wb_ic_pkg;

  localparam int DAT_W      = 32;
  localparam int SLOT_GPIO  = 0;
  localparam int SLOT_LA    = 1;
  localparam int SLOT_TEAM0 = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/wb_team_interconnect_if.sv
// wb_team_interconnect_if: Wishbone classic master-side bus between the
// Caravel user-area port and the interconnect.
//   wbs_stb_i / wbs_cyc_i / wbs_adr_i   driven by the master
//   wbs_ack_o / wbs_dat_o               returned by the interconnect
// Modports: master (Caravel side), slave (interconnect side).
interface wb_team_interconnect_if;
  import wb_ic_pkg::*;

  logic             wbs_stb_i;
  logic             wbs_cyc_i;
  logic [31:0]      wbs_adr_i;
  logic             wbs_ack_o;
  logic [DAT_W-1:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_team_interconnect_timer.sv
// wb_timeout_timer: per-transfer timeout counter.
//   clk, rst  clock and synchronous active-high reset
//   clear     force the count back to zero
//   enable    count up by one per cycle while below the terminal value
//   done      count has reached TIMEOUT_CYCLES-1
module wb_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CNT_W'(1);
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/wb_team_interconnect.sv
// wb_team_interconnect: Wishbone classic interconnect from the Caravel
// user-area port to gpio_control, la_control and NUM_TEAMS team wrappers.
// Decodes the slot field, drives one registered strobe, returns the selected
// slave's data/ack, and answers unmapped slots and stalled slaves with an
// error response carrying BAD_DATA.
// Ports:
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   bus                    master-side Wishbone (slave modport)
//   *_stb                  registered strobes: gpio slot 0, la slot 1,
//                          designs_stb[i] = team i+1 = slot i+2
//   adr_truncated          {16'h0, latched adr[15:0]}
//   *_dat_o / *_ack_o      slave read data and acks
//   err_count, err_pulse   saturating error count, pulse per error response
//
// state | meaning
// IDLE  | waiting for stb&cyc, timer held clear
// BUSY  | one slave strobe high, waiting for its ack, abort or timeout
// RESP  | wbs_ack_o high for this single cycle
module wb_team_interconnect
  import wb_ic_pkg::*;
#(
  parameter int          NUM_TEAMS      = 1,
  parameter int          SLOT_LSB       = 16,
  parameter int          SLOT_W         = 8,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] BAD_DATA       = 32'hBADD_A7A0
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  wb_team_interconnect_if.slave      bus,
  output logic                       gpio_control_stb,
  output logic                       la_control_stb,
  output logic [NUM_TEAMS-1:0]       designs_stb,
  output logic [31:0]                adr_truncated,
  input  logic [DAT_W-1:0]           gpio_control_dat_o,
  input  logic [DAT_W-1:0]           la_control_dat_o,
  input  logic [DAT_W*NUM_TEAMS-1:0] designs_dat_o,
  input  logic                       gpio_control_ack_o,
  input  logic                       la_control_ack_o,
  input  logic [NUM_TEAMS-1:0]       designs_ack_o,
  output logic [15:0]                err_count,
  output logic                       err_pulse
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]           state;
  logic [SLOT_W-1:0]    sel_slot;
  logic [15:0]          adr_q;
  logic                 ack_q;
  logic [DAT_W-1:0]     dat_q;
  logic                 gpio_stb_q;
  logic                 la_stb_q;
  logic [NUM_TEAMS-1:0] team_stb_q;
  logic [15:0]          err_cnt_q;
  logic                 err_pulse_q;

  logic [SLOT_W-1:0]    req_slot;
  int                   req_idx;
  int                   sel_idx;
  logic                 req_mapped;
  logic                 dec_gpio;
  logic                 dec_la;
  logic [NUM_TEAMS-1:0] dec_team;
  logic                 sel_ack;
  logic [DAT_W-1:0]     sel_dat;
  logic                 tmr_done;
  logic                 unused_adr;

  assign req_slot   = bus.wbs_adr_i[SLOT_LSB +: SLOT_W];
  assign req_idx    = int'(req_slot);
  assign sel_idx    = int'(sel_slot);
  assign req_mapped = (req_idx < NUM_TEAMS + 2);
  // Address bits outside the slot field and adr[15:0] carry no meaning here.
  assign unused_adr = ^bus.wbs_adr_i;

  always_comb begin
    dec_gpio = (req_idx == SLOT_GPIO);
    dec_la   = (req_idx == SLOT_LA);
    dec_team = '0;
    for (int i = 0; i < NUM_TEAMS; i++) begin
      dec_team[i] = (req_idx == SLOT_TEAM0 + i);
    end
  end

  // Return path follows the latched slot, so acks from any other slave
  // never reach the FSM.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    if (sel_idx == SLOT_GPIO) begin
      sel_ack = gpio_control_ack_o;
      sel_dat = gpio_control_dat_o;
    end
    if (sel_idx == SLOT_LA) begin
      sel_ack = la_control_ack_o;
      sel_dat = la_control_dat_o;
    end
    for (int i = 0; i < NUM_TEAMS; i++) begin
      if (sel_idx == SLOT_TEAM0 + i) begin
        sel_ack = designs_ack_o[i];
        sel_dat = designs_dat_o[DAT_W*i +: DAT_W];
      end
    end
  end

  wb_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .clear (state == ST_IDLE),
    .enable(state == ST_BUSY),
    .done  (tmr_done)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      sel_slot    <= '0;
      adr_q       <= '0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      gpio_stb_q  <= 1'b0;
      la_stb_q    <= 1'b0;
      team_stb_q  <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.wbs_stb_i && bus.wbs_cyc_i) begin
            sel_slot <= req_slot;
            adr_q    <= bus.wbs_adr_i[15:0];
            if (req_mapped) begin
              gpio_stb_q <= dec_gpio;
              la_stb_q   <= dec_la;
              team_stb_q <= dec_team;
              state      <= ST_BUSY;
            end else begin
              dat_q       <= BAD_DATA;
              ack_q       <= 1'b1;
              err_pulse_q <= 1'b1;
              err_cnt_q   <= sat_inc16(err_cnt_q);
              state       <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          // Abort beats ack: with cyc gone there is no master left to answer.
          if (!bus.wbs_cyc_i) begin
            gpio_stb_q <= 1'b0;
            la_stb_q   <= 1'b0;
            team_stb_q <= '0;
            state      <= ST_IDLE;
          end else if (sel_ack) begin
            dat_q      <= sel_dat;
            ack_q      <= 1'b1;
            gpio_stb_q <= 1'b0;
            la_stb_q   <= 1'b0;
            team_stb_q <= '0;
            state      <= ST_RESP;
          end else if (tmr_done) begin
            dat_q       <= BAD_DATA;
            ack_q       <= 1'b1;
            err_pulse_q <= 1'b1;
            err_cnt_q   <= sat_inc16(err_cnt_q);
            gpio_stb_q  <= 1'b0;
            la_stb_q    <= 1'b0;
            team_stb_q  <= '0;
            state       <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wbs_ack_o     = ack_q;
  assign bus.wbs_dat_o     = dat_q;
  assign gpio_control_stb  = gpio_stb_q;
  assign la_control_stb    = la_stb_q;
  assign designs_stb       = team_stb_q;
  assign adr_truncated     = {16'h0, adr_q};
  assign err_count         = err_cnt_q;
  assign err_pulse         = err_pulse_q;

endmodule

// File: tb/tb_wb_team_interconnect.sv
// Directed bench for wb_team_interconnect with NUM_TEAMS=4, TIMEOUT_CYCLES=8.
// Cycle numbering: the request is driven in cycle 0; each step() advances to
// the next cycle and samples 1 time unit after the rising edge.
module tb_wb_team_interconnect;
  import wb_ic_pkg::*;

  localparam logic [31:0] BAD  = 32'hBADD_A7A0;
  localparam logic [31:0] GDAT = 32'h6910_0000;
  localparam logic [31:0] LDAT = 32'h1A00_0001;

  logic         clk;
  logic         rst;
  logic         gpio_stb;
  logic         la_stb;
  logic [3:0]   team_stb;
  logic [31:0]  adr_trunc;
  logic         gpio_ack;
  logic         la_ack;
  logic [3:0]   team_ack;
  logic [127:0] team_dat;
  logic [15:0]  err_cnt;
  logic         err_p;
  logic         ack_seen;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wb_team_interconnect_if bus();

  wb_team_interconnect #(
    .NUM_TEAMS     (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .wb_clk_i          (clk),
    .wb_rst_i          (rst),
    .bus               (bus),
    .gpio_control_stb  (gpio_stb),
    .la_control_stb    (la_stb),
    .designs_stb       (team_stb),
    .adr_truncated     (adr_trunc),
    .gpio_control_dat_o(GDAT),
    .la_control_dat_o  (LDAT),
    .designs_dat_o     (team_dat),
    .gpio_control_ack_o(gpio_ack),
    .la_control_ack_o  (la_ack),
    .designs_ack_o     (team_ack),
    .err_count         (err_cnt),
    .err_pulse         (err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a);
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_adr_i = a;
  endtask

  task automatic idle_bus();
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    gpio_ack  = 1'b0;
    la_ack    = 1'b0;
    team_ack  = 4'b0;
    team_dat  = {32'h7EA0_0003, 32'h1234_5678, 32'h7EA0_0001, 32'h7EA0_0000};
    bus.wbs_adr_i = 32'h0;
    idle_bus();
    step();
    step();

    // Reset state
    chk("rst_ack",   32'(bus.wbs_ack_o), 32'h0);
    chk("rst_dat",   bus.wbs_dat_o,      32'h0);
    chk("rst_stb",   32'({gpio_stb, la_stb, team_stb}), 32'h0);
    chk("rst_adr",   adr_trunc,          32'h0);
    chk("rst_err",   32'(err_cnt),       32'h0);
    chk("rst_errp",  32'(err_p),         32'h0);
    rst = 1'b0;
    step();

    // T1: slot 4 = team3, ack driven in cycle 4 -> wbs_ack_o in cycle 5
    req(32'h3004_0010);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("t1_team_stb", 32'(team_stb), 32'h4);
      chk("t1_no_ack",   32'(bus.wbs_ack_o), 32'h0);
    end
    chk("t1_other_stb", 32'({gpio_stb, la_stb}), 32'h0);
    team_ack = 4'b0100;
    step();
    team_ack = 4'b0;
    chk("t1_ack",     32'(bus.wbs_ack_o), 32'h1);
    chk("t1_dat",     bus.wbs_dat_o,      32'h1234_5678);
    chk("t1_stb_off", 32'(team_stb),      32'h0);
    chk("t1_adr",     adr_trunc,          32'h0000_0010);
    chk("t1_errp",    32'(err_p),         32'h0);
    step();
    idle_bus();
    chk("t1_ack_one", 32'(bus.wbs_ack_o), 32'h0);
    chk("t1_dat_hold", bus.wbs_dat_o,     32'h1234_5678);

    // T2: slot 9 unmapped -> error response in cycle 1
    req(32'h3009_0000);
    step();
    chk("t2_ack",  32'(bus.wbs_ack_o), 32'h1);
    chk("t2_dat",  bus.wbs_dat_o,      BAD);
    chk("t2_errp", 32'(err_p),         32'h1);
    chk("t2_err",  32'(err_cnt),       32'h1);
    chk("t2_stb",  32'({gpio_stb, la_stb, team_stb}), 32'h0);
    step();
    idle_bus();
    chk("t2_ack_one",  32'(bus.wbs_ack_o), 32'h0);
    chk("t2_errp_one", 32'(err_p),         32'h0);
    chk("t2_adr",      adr_trunc,          32'h0);

    // T3: gpio never acks -> strobe cycles 1..8, error ack in cycle 9
    req(32'h3000_0004);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("t3_gpio_stb", 32'(gpio_stb), 32'h1);
    end
    chk("t3_err_before", 32'(err_cnt), 32'h1);
    step();
    chk("t3_ack",     32'(bus.wbs_ack_o), 32'h1);
    chk("t3_dat",     bus.wbs_dat_o,      BAD);
    chk("t3_errp",    32'(err_p),         32'h1);
    chk("t3_err",     32'(err_cnt),       32'h2);
    chk("t3_stb_off", 32'(gpio_stb),      32'h0);
    step();
    idle_bus();
    chk("t3_ack_one", 32'(bus.wbs_ack_o), 32'h0);

    // T4: la acks in BUSY cycle 8, the timeout cycle -> ack wins
    req(32'h3001_0020);
    for (int c = 1; c <= 8; c++) begin
      step();
      chk("t4_la_stb", 32'(la_stb), 32'h1);
    end
    la_ack = 1'b1;
    step();
    la_ack = 1'b0;
    chk("t4_ack",  32'(bus.wbs_ack_o), 32'h1);
    chk("t4_dat",  bus.wbs_dat_o,      LDAT);
    chk("t4_errp", 32'(err_p),         32'h0);
    chk("t4_err",  32'(err_cnt),       32'h2);
    step();
    idle_bus();

    // T5: cyc dropped in BUSY cycle 2 -> strobe low in cycle 3, never acked
    req(32'h3002_0000);
    step();
    chk("t5_stb_c1", 32'(team_stb), 32'h1);
    step();
    chk("t5_stb_c2", 32'(team_stb), 32'h1);
    idle_bus();
    step();
    chk("t5_stb_c3", 32'(team_stb), 32'h0);
    ack_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bus.wbs_ack_o) ack_seen = 1'b1;
      step();
    end
    chk("t5_no_ack", 32'(ack_seen), 32'h0);
    chk("t5_err",    32'(err_cnt),  32'h2);
    // follow-up request to team2 (slot 3), zero-wait
    req(32'h3003_0044);
    step();
    chk("t5b_stb", 32'(team_stb), 32'h2);
    team_ack = 4'b0010;
    step();
    team_ack = 4'b0;
    chk("t5b_ack", 32'(bus.wbs_ack_o), 32'h1);
    chk("t5b_dat", bus.wbs_dat_o,      32'h7EA0_0001);
    chk("t5b_adr", adr_trunc,          32'h0000_0044);
    step();

    // T6: back-to-back slots 0,1,2 with zero-wait slaves, ack every 3rd cycle
    req(32'h3000_0100);
    step();
    chk("t6a_stb",    32'(gpio_stb),      32'h1);
    chk("t6a_no_ack", 32'(bus.wbs_ack_o), 32'h0);
    gpio_ack = 1'b1;
    step();
    gpio_ack = 1'b0;
    chk("t6a_ack", 32'(bus.wbs_ack_o), 32'h1);
    chk("t6a_dat", bus.wbs_dat_o,      GDAT);
    step();
    req(32'h3001_0104);
    step();
    chk("t6b_stb",    32'(la_stb),        32'h1);
    chk("t6b_no_ack", 32'(bus.wbs_ack_o), 32'h0);
    la_ack = 1'b1;
    step();
    la_ack = 1'b0;
    chk("t6b_ack", 32'(bus.wbs_ack_o), 32'h1);
    chk("t6b_dat", bus.wbs_dat_o,      LDAT);
    step();
    req(32'h3002_0108);
    step();
    chk("t6c_stb",    32'(team_stb),      32'h1);
    chk("t6c_no_ack", 32'(bus.wbs_ack_o), 32'h0);
    team_ack = 4'b0001;
    step();
    team_ack = 4'b0;
    chk("t6c_ack", 32'(bus.wbs_ack_o), 32'h1);
    chk("t6c_dat", bus.wbs_dat_o,      32'h7EA0_0000);
    chk("t6c_adr", adr_trunc,          32'h0000_0108);
    step();

    // stray acks from non-selected slaves while team4 (slot 5) is busy
    req(32'h3005_0000);
    step();
    chk("t6d_stb", 32'(team_stb), 32'h8);
    team_ack = 4'b0001;
    gpio_ack = 1'b1;
    step();
    team_ack = 4'b0;
    gpio_ack = 1'b0;
    chk("t6d_stray_ack", 32'(bus.wbs_ack_o), 32'h0);
    chk("t6d_stb_hold",  32'(team_stb),      32'h8);

    // reset while BUSY
    rst = 1'b1;
    idle_bus();
    step();
    chk("t6e_stb",  32'({gpio_stb, la_stb, team_stb}), 32'h0);
    chk("t6e_ack",  32'(bus.wbs_ack_o), 32'h0);
    chk("t6e_dat",  bus.wbs_dat_o,      32'h0);
    chk("t6e_adr",  adr_trunc,          32'h0);
    chk("t6e_err",  32'(err_cnt),       32'h0);
    chk("t6e_errp", 32'(err_p),         32'h0);
    rst = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (bus.wbs_ack_o) ack_seen = 1'b1;
    end
    chk("t6e_no_ack", 32'(ack_seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
